// File: rtl/picmicro_fetch_sequencer_if.sv
// Fetch-side bus between the Q-cycle sequencer and its neighbours (decode, pclath, program memory).
// master = sequencer, slave = the surrounding core / program memory.
interface picmicro_fetch_sequencer_if #(
   parameter int PC_WIDTH = 13
);
   logic [1:0]          q_phase;
   logic                instr_rd_en;
   logic [PC_WIDTH-1:0] pc_out;
   logic                flush;
   logic                stack_ovf;
   logic                stack_unf;
   logic [4:0]          pclath_in;
   logic                ctl_goto;
   logic                ctl_call;
   logic                ctl_return;
   logic                ctl_pcl_wr;
   logic                ctl_skip;
   logic [10:0]         target_addr;
   logic [7:0]          pcl_data;

   modport master (
      output q_phase, instr_rd_en, pc_out, flush, stack_ovf, stack_unf,
      input  pclath_in, ctl_goto, ctl_call, ctl_return, ctl_pcl_wr, ctl_skip,
             target_addr, pcl_data
   );

   modport slave (
      input  q_phase, instr_rd_en, pc_out, flush, stack_ovf, stack_unf,
      output pclath_in, ctl_goto, ctl_call, ctl_return, ctl_pcl_wr, ctl_skip,
             target_addr, pcl_data
   );
endinterface

// File: rtl/picmicro_fetch_sequencer.sv
// Q1..Q4 instruction-cycle sequencer with program counter, redirect flush and
// a circular hardware return stack. All PC/stack/flush state moves only at the end of Q4.
module picmicro_fetch_sequencer #(
   parameter int                  PC_WIDTH     = 13,
   parameter int                  STACK_DEPTH  = 8,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
   input logic                          clk,
   input logic                          rst,
   picmicro_fetch_sequencer_if.master   bus
);
   localparam int             SP_W = $clog2(STACK_DEPTH);
   localparam logic [SP_W:0]  FULL = (SP_W + 1)'(STACK_DEPTH);

   typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} q_phase_t;

   q_phase_t            q_phase_q, q_phase_d;
   logic                instr_rd_en_q;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                flush_q, flush_d;
   logic [SP_W-1:0]     sp_q, sp_d;
   logic [SP_W:0]       count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;
   logic                push;
   logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
   logic [PC_WIDTH-1:0] jump_addr;
   logic [PC_WIDTH-1:0] pcl_addr;
   logic [SP_W-1:0]     sp_prev;

   assign jump_addr = PC_WIDTH'({bus.pclath_in[4:3], bus.target_addr});
   assign pcl_addr  = PC_WIDTH'({bus.pclath_in, bus.pcl_data});
   assign sp_prev   = sp_q - SP_W'(1);

   always_comb begin
      q_phase_d = q_phase_q;
      pc_d      = pc_q;
      flush_d   = flush_q;
      sp_d      = sp_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      push      = 1'b0;

      case (q_phase_q)
         Q1:      q_phase_d = Q2;
         Q2:      q_phase_d = Q3;
         Q3:      q_phase_d = Q4;
         default: q_phase_d = Q1;
      endcase

      if (q_phase_q == Q4) begin
         pc_d    = pc_q + PC_WIDTH'(1);
         flush_d = 1'b0;
         // The instruction executing in a flush cycle is a forced NOP, so its strobes are dropped.
         if (!flush_q) begin
            if (bus.ctl_return) begin
               pc_d    = stack_q[sp_prev];
               sp_d    = sp_prev;
               flush_d = 1'b1;
               if (count_q == '0) unf_d = 1'b1;
               else               count_d = count_q - (SP_W + 1)'(1);
            end else if (bus.ctl_call) begin
               push    = 1'b1;
               sp_d    = sp_q + SP_W'(1);
               pc_d    = jump_addr;
               flush_d = 1'b1;
               if (count_q == FULL) ovf_d = 1'b1;
               else                 count_d = count_q + (SP_W + 1)'(1);
            end else if (bus.ctl_goto) begin
               pc_d    = jump_addr;
               flush_d = 1'b1;
            end else if (bus.ctl_pcl_wr) begin
               pc_d    = pcl_addr;
               flush_d = 1'b1;
            end else if (bus.ctl_skip) begin
               flush_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_phase_q     <= Q1;
         instr_rd_en_q <= 1'b0;
         pc_q          <= RESET_VECTOR;
         flush_q       <= 1'b1;
         sp_q          <= '0;
         count_q       <= '0;
         ovf_q         <= 1'b0;
         unf_q         <= 1'b0;
      end else begin
         q_phase_q     <= q_phase_d;
         instr_rd_en_q <= (q_phase_d == Q4);
         pc_q          <= pc_d;
         flush_q       <= flush_d;
         sp_q          <= sp_d;
         count_q       <= count_d;
         ovf_q         <= ovf_d;
         unf_q         <= unf_d;
      end
   end

   // Stack storage is deliberately not reset; when full, sp already points at the oldest entry.
   always_ff @(posedge clk) begin
      if (push) stack_q[sp_q] <= pc_q;
   end

   assign bus.q_phase     = q_phase_q;
   assign bus.instr_rd_en = instr_rd_en_q;
   assign bus.pc_out      = pc_q;
   assign bus.flush       = flush_q;
   assign bus.stack_ovf   = ovf_q;
   assign bus.stack_unf   = unf_q;
endmodule

// File: tb/tb_picmicro_fetch_sequencer.sv
// Directed bench for the fetch sequencer: phase counter, redirects, return stack limits, reset.
module tb_picmicro_fetch_sequencer;
   logic clk;
   logic rst;
   int   tests_run = 0;
   int   tests_failed = 0;
   logic [12:0] ra [1:9];

   picmicro_fetch_sequencer_if #(.PC_WIDTH(13)) bus ();

   picmicro_fetch_sequencer #(
      .PC_WIDTH(13), .STACK_DEPTH(8), .RESET_VECTOR(13'h0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive strobes for one whole instruction cycle starting in Q1; returns in Q1 of the next cycle.
   task automatic run_cycle(input bit g, input bit c, input bit r, input bit p, input bit s,
                            input logic [10:0] k, input logic [4:0] pl, input logic [7:0] pd);
      bus.ctl_goto    = g;
      bus.ctl_call    = c;
      bus.ctl_return  = r;
      bus.ctl_pcl_wr  = p;
      bus.ctl_skip    = s;
      bus.target_addr = k;
      bus.pclath_in   = pl;
      bus.pcl_data    = pd;
      repeat (4) @(posedge clk);
      #1;
      bus.ctl_goto   = 1'b0;
      bus.ctl_call   = 1'b0;
      bus.ctl_return = 1'b0;
      bus.ctl_pcl_wr = 1'b0;
      bus.ctl_skip   = 1'b0;
      $display("[TB] cycle g=%0b c=%0b r=%0b p=%0b s=%0b -> pc_out=0x%04h flush=%0b",
               g, c, r, p, s, bus.pc_out, bus.flush);
   endtask

   task automatic idle_cycle();
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 5'h00, 8'h00);
   endtask

   initial begin
      rst = 1'b0;
      bus.ctl_goto = 1'b0; bus.ctl_call = 1'b0; bus.ctl_return = 1'b0;
      bus.ctl_pcl_wr = 1'b0; bus.ctl_skip = 1'b0;
      bus.target_addr = '0; bus.pclath_in = '0; bus.pcl_data = '0;
      #12;
      check("rst_q_phase", 32'(bus.q_phase), 0);
      check("rst_pc", 32'(bus.pc_out), 13'h0000);
      check("rst_flush", 32'(bus.flush), 1);
      check("rst_rd_en", 32'(bus.instr_rd_en), 0);
      check("rst_ovf", 32'(bus.stack_ovf), 0);
      check("rst_unf", 32'(bus.stack_unf), 0);
      rst = 1'b1;

      // 1: phase sequence, read enable only in Q4, pc steady mid-cycle
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1;
         check("t1_q_phase", 32'(bus.q_phase), 32'(i));
         check("t1_rd_en", 32'(bus.instr_rd_en), (i == 3) ? 1 : 0);
         check("t1_pc_hold", 32'(bus.pc_out), 0);
         check("t1_flush_first", 32'(bus.flush), 1);
      end
      @(posedge clk); #1;
      $display("[TB] first cycle done pc_out=0x%04h flush=%0b", bus.pc_out, bus.flush);
      check("t1_q_wrap", 32'(bus.q_phase), 0);
      check("t1_rd_en_off", 32'(bus.instr_rd_en), 0);
      check("t1_pc1", 32'(bus.pc_out), 1);
      check("t1_flush_clr", 32'(bus.flush), 0);
      idle_cycle(); check("t1_pc2", 32'(bus.pc_out), 2);
      idle_cycle(); check("t1_pc3", 32'(bus.pc_out), 3);
      check("t1_flush_stays0", 32'(bus.flush), 0);

      // 2: GOTO with PCLATH page bits
      idle_cycle(); idle_cycle();
      check("t2_pc5", 32'(bus.pc_out), 5);
      run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h123, 5'b11000, 8'h00);
      check("t2_goto_pc", 32'(bus.pc_out), 13'h1923);
      check("t2_flush_q1", 32'(bus.flush), 1);
      // 5b: CALL during the flush cycle must be ignored; flush lasts exactly 4 clocks
      bus.ctl_call = 1'b1; bus.target_addr = 11'h7FF; bus.pclath_in = 5'b00000;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1;
         check("t2_flush_held", 32'(bus.flush), 1);
      end
      @(posedge clk); #1;
      bus.ctl_call = 1'b0;
      $display("[TB] flush cycle with call -> pc_out=0x%04h flush=%0b", bus.pc_out, bus.flush);
      check("t2_flush_end", 32'(bus.flush), 0);
      check("t5_call_ignored_pc", 32'(bus.pc_out), 13'h1924);

      // 5a: goto beats skip
      run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'h055, 5'h00, 8'h00);
      check("t5_goto_wins", 32'(bus.pc_out), 13'h0055);
      check("t5_goto_flush", 32'(bus.flush), 1);
      idle_cycle(); check("t5_after_flush", 32'(bus.pc_out), 13'h0056);

      // 3: CALL / RETURN round trip
      run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h010, 5'h00, 8'h00);
      idle_cycle(); check("t3_pc11", 32'(bus.pc_out), 13'h0011);
      run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h040, 5'h00, 8'h00);
      check("t3_call_pc", 32'(bus.pc_out), 13'h0040);
      check("t3_call_flush", 32'(bus.flush), 1);
      idle_cycle(); idle_cycle(); idle_cycle();
      check("t3_pc43", 32'(bus.pc_out), 13'h0043);
      run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 5'h00, 8'h00);
      check("t3_return_pc", 32'(bus.pc_out), 13'h0011);
      check("t3_return_flush", 32'(bus.flush), 1);
      idle_cycle(); check("t3_pc12", 32'(bus.pc_out), 13'h0012);
      check("t3_no_unf", 32'(bus.stack_unf), 0);

      // 4: nine nested calls then nine returns
      ra[1] = 13'h0012;
      for (int i = 1; i <= 9; i++) begin
         run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'(i * 32'h80), 5'h00, 8'h00);
         check("t4_call_pc", 32'(bus.pc_out), 32'(i * 32'h80));
         check("t4_ovf", 32'(bus.stack_ovf), (i == 9) ? 1 : 0);
         idle_cycle();
         if (i < 9) ra[i + 1] = 13'(i * 32'h80 + 1);
      end
      for (int k = 1; k <= 9; k++) begin
         run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 5'h00, 8'h00);
         check("t4_ret_pc", 32'(bus.pc_out), (k == 9) ? 32'(ra[9]) : 32'(ra[10 - k]));
         check("t4_unf", 32'(bus.stack_unf), (k == 9) ? 1 : 0);
         idle_cycle();
      end
      check("t4_ovf_sticky", 32'(bus.stack_ovf), 1);

      // 6: pc wrap, PCL write, plain skip
      run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h7FF, 5'b11000, 8'h00);
      check("t6_pc_1fff", 32'(bus.pc_out), 13'h1FFF);
      idle_cycle(); check("t6_wrap", 32'(bus.pc_out), 13'h0000);
      run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h000, 5'h0C, 8'hA5);
      check("t6_pcl_wr", 32'(bus.pc_out), 13'h0CA5);
      check("t6_pcl_flush", 32'(bus.flush), 1);
      idle_cycle(); check("t6_pc_ca6", 32'(bus.pc_out), 13'h0CA6);
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 5'h00, 8'h00);
      check("t6_skip_pc", 32'(bus.pc_out), 13'h0CA7);
      check("t6_skip_flush", 32'(bus.flush), 1);
      check("t6_unf_sticky", 32'(bus.stack_unf), 1);

      // 6: asynchronous reset in Q2
      @(posedge clk); #1;
      check("t6_in_q2", 32'(bus.q_phase), 1);
      #1 rst = 1'b0;
      #1;
      $display("[TB] reset in Q2 -> q=%0d pc_out=0x%04h flush=%0b", bus.q_phase, bus.pc_out, bus.flush);
      check("t6_rst_q", 32'(bus.q_phase), 0);
      check("t6_rst_pc", 32'(bus.pc_out), 0);
      check("t6_rst_flush", 32'(bus.flush), 1);
      check("t6_rst_ovf", 32'(bus.stack_ovf), 0);
      check("t6_rst_unf", 32'(bus.stack_unf), 0);
      @(negedge clk);
      rst = 1'b1;
      idle_cycle();
      check("t6_post_rst_pc", 32'(bus.pc_out), 1);
      check("t6_post_rst_flush", 32'(bus.flush), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
